// File: rtl/arbiter_onehot_param.sv
// arbiter_onehot_param
//   Registered WIDTH-line arbiter. It issues a one-hot grant plus the grant's
//   binary index and holds that grant until the consumer acknowledges it.
//   MODE=0 gives fixed priority, with the MSB highest. MODE=1 gives
//   round-robin order.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   req        request vector, bit i = requester i
//   ack        consumer accepts the current grant (ignored while valid=0)
//   grant      registered one-hot grant, zero when valid=0
//   grant_idx  binary index of the granted bit, zero when valid=0
//   valid      grant/grant_idx are valid
module arbiter_onehot_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = $clog2(WIDTH),
  parameter int unsigned MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             ack,
  output logic [WIDTH-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] grant_d;
  logic [IDX_W-1:0] idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] sel_idx;
  logic             load;

  // Winner selection from the current req.
  // Round-robin walks the search order backwards (ptr+1 ... ptr). Each set
  // bit overwrites sel_idx, so the last one written is the first set bit in
  // the real search order ptr, ptr-1, ..., 0, WIDTH-1, ..., ptr+1.
  always_comb begin
    int unsigned p;
    int unsigned k;
    int unsigned pos;
    sel_idx = '0;
    p       = 0;
    k       = 0;
    pos     = 0;
    if (MODE == 0) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (req[IDX_W'(i)]) sel_idx = IDX_W'(i);
      end
    end else begin
      p = int'(ptr_q);
      for (int unsigned n = 0; n < WIDTH; n++) begin
        k   = WIDTH - 1 - n;
        pos = (p >= k) ? (p - k) : (p + WIDTH - k);
        if (req[IDX_W'(pos)]) sel_idx = IDX_W'(pos);
      end
    end
  end

  // Next-state logic. In GRANT with ack=0 the req value is never consulted,
  // so an X on req cannot reach the registers.
  always_comb begin
    state_d = state_q;
    grant_d = grant;
    idx_d   = grant_idx;
    ptr_d   = ptr_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          load    = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (ack) begin
          if (|req) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            idx_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      grant_d          = '0;
      grant_d[sel_idx] = 1'b1;
      idx_d            = sel_idx;
      if (MODE != 0) begin
        ptr_d = (sel_idx == '0) ? PTR_RST : (sel_idx - IDX_W'(1));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      ptr_q     <= PTR_RST;
    end else begin
      state_q   <= state_d;
      grant     <= grant_d;
      grant_idx <= idx_d;
      ptr_q     <= ptr_d;
    end
  end

  assign valid = (state_q == GRANT);

endmodule

// File: tb/tb_arbiter_onehot_param.sv
// tb_arbiter_onehot_param
//   Drives one fixed-priority instance and one round-robin instance of
//   arbiter_onehot_param (WIDTH=8). Each instance has its own req/ack.
//   Directed scenarios are followed by a randomized run. The randomized run
//   is compared against a behavioural model that tracks the last granted
//   index.
module tb_arbiter_onehot_param;

  logic       clk;
  logic       rst;
  logic [7:0] req_a   [2];
  logic       ack_a   [2];
  logic [7:0] grant_a [2];
  logic [2:0] idx_a   [2];
  logic       valid_a [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state per instance (0 = fixed, 1 = round-robin)
  bit mv  [2];
  int mg  [2];
  int mlg [2];

  arbiter_onehot_param #(.WIDTH(8), .MODE(0)) u_fixed (
    .clk(clk), .rst(rst), .req(req_a[0]), .ack(ack_a[0]),
    .grant(grant_a[0]), .grant_idx(idx_a[0]), .valid(valid_a[0])
  );

  arbiter_onehot_param #(.WIDTH(8), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .req(req_a[1]), .ack(ack_a[1]),
    .grant(grant_a[1]), .grant_idx(idx_a[1]), .valid(valid_a[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed: the highest set bit wins.
  // Round-robin: the winner is the set bit that comes soonest when counting
  // downward, with wrap, starting just below the last granted index.
  function automatic int pick(input logic [7:0] r, input int mode, input int lg);
    int w;
    int best;
    int d;
    w    = -1;
    best = 99;
    d    = 0;
    for (int i = 0; i < 8; i++) begin
      if (r[i]) begin
        if (mode == 0) begin
          w = i;
        end else begin
          d = (lg - 1 - i + 16) % 8;
          if (d < best) begin
            best = d;
            w    = i;
          end
        end
      end
    end
    return w;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        mv[m]  = 1'b0;
        mg[m]  = 0;
        mlg[m] = 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (!mv[m] || ack_a[m]) begin
          if (req_a[m] != 8'h00) begin
            mv[m]  = 1'b1;
            mg[m]  = pick(req_a[m], m, mlg[m]);
            mlg[m] = mg[m];
          end else if (mv[m]) begin
            mv[m] = 1'b0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int m, input logic [7:0] r, input logic a);
    req_a[m] = r;
    ack_a[m] = a;
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    drive(0, 8'h26, 1'b0);
    drive(1, 8'h01, 1'b0);
    step();
    n_checks++;
    if (valid_a[0] !== 1'b1 || valid_a[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_precond: valid got %b%b expected 11", valid_a[0], valid_a[1]);
    end
    #2 rst = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      obs = {valid_a[m], idx_a[m], grant_a[m]};
      n_checks++;
      if (obs !== 12'h000) begin
        n_fail++;
        $display("FAIL async_reset[%0d]: {valid,idx,grant} got %h expected 000", m, obs);
      end
    end
    @(negedge clk);
    drive(0, 8'h00, 1'b0);
    drive(1, 8'h00, 1'b0);
    rst = 1'b0;
    step();
  endtask

  task automatic test_fixed_hold();
    logic [11:0] obs;
    drive(0, 8'h26, 1'b0);
    step();
    obs = {valid_a[0], idx_a[0], grant_a[0]};
    n_checks++;
    if (obs !== {1'b1, 3'd5, 8'h20}) begin
      n_fail++;
      $display("FAIL fixed_first: got %h expected %h", obs, {1'b1, 3'd5, 8'h20});
    end
    drive(0, 8'h01, 1'b0);
    for (int n = 0; n < 3; n++) begin
      step();
      obs = {valid_a[0], idx_a[0], grant_a[0]};
      n_checks++;
      if (obs !== {1'b1, 3'd5, 8'h20}) begin
        n_fail++;
        $display("FAIL fixed_hold[%0d]: got %h expected %h", n, obs, {1'b1, 3'd5, 8'h20});
      end
    end
  endtask

  task automatic test_fixed_back_to_back();
    logic [11:0] obs;
    drive(0, 8'h06, 1'b1);
    step();
    obs = {valid_a[0], idx_a[0], grant_a[0]};
    n_checks++;
    if (obs !== {1'b1, 3'd2, 8'h04}) begin
      n_fail++;
      $display("FAIL fixed_b2b: got %h expected %h", obs, {1'b1, 3'd2, 8'h04});
    end
    drive(0, 8'h00, 1'b1);
    step();
    obs = {valid_a[0], idx_a[0], grant_a[0]};
    n_checks++;
    if (obs !== 12'h000) begin
      n_fail++;
      $display("FAIL fixed_release: got %h expected 000", obs);
    end
    drive(0, 8'h00, 1'b0);
  endtask

  task automatic test_rr_rotation();
    logic [11:0] obs;
    logic [11:0] exp;
    drive(1, 8'hFF, 1'b1);
    for (int n = 0; n < 9; n++) begin
      step();
      exp = {1'b1, 3'(7 - (n % 8)), 8'h80 >> (n % 8)};
      obs = {valid_a[1], idx_a[1], grant_a[1]};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL rr_rotation[%0d]: got %h expected %h", n, obs, exp);
      end
    end
    drive(1, 8'h00, 1'b1);
    step();
    drive(1, 8'h00, 1'b0);
  endtask

  task automatic test_rr_wrap();
    logic [11:0] obs;
    drive(1, 8'h20, 1'b0);
    step();
    obs = {valid_a[1], idx_a[1], grant_a[1]};
    n_checks++;
    if (obs !== {1'b1, 3'd5, 8'h20}) begin
      n_fail++;
      $display("FAIL rr_single: got %h expected %h", obs, {1'b1, 3'd5, 8'h20});
    end
    drive(1, 8'h21, 1'b1);
    step();
    obs = {valid_a[1], idx_a[1], grant_a[1]};
    n_checks++;
    if (obs !== {1'b1, 3'd0, 8'h01}) begin
      n_fail++;
      $display("FAIL rr_to_zero: got %h expected %h", obs, {1'b1, 3'd0, 8'h01});
    end
    step();
    obs = {valid_a[1], idx_a[1], grant_a[1]};
    n_checks++;
    if (obs !== {1'b1, 3'd5, 8'h20}) begin
      n_fail++;
      $display("FAIL rr_wrap: got %h expected %h", obs, {1'b1, 3'd5, 8'h20});
    end
    drive(1, 8'h00, 1'b1);
    step();
    drive(1, 8'h00, 1'b0);
  endtask

  task automatic test_idle_ack();
    logic [11:0] obs;
    drive(0, 8'h00, 1'b1);
    drive(1, 8'h00, 1'b1);
    step();
    drive(0, 8'h00, 1'b0);
    drive(1, 8'h00, 1'b0);
    step();
    for (int m = 0; m < 2; m++) begin
      obs = {valid_a[m], idx_a[m], grant_a[m]};
      n_checks++;
      if (obs !== 12'h000) begin
        n_fail++;
        $display("FAIL idle_ack[%0d]: got %h expected 000", m, obs);
      end
    end
  endtask

  task automatic test_x_hold();
    logic [11:0] obs;
    drive(0, 8'h80, 1'b0);
    step();
    drive(0, 8'bxxxx_xxxx, 1'b0);
    for (int n = 0; n < 3; n++) begin
      step();
      obs = {valid_a[0], idx_a[0], grant_a[0]};
      n_checks++;
      if (obs !== {1'b1, 3'd7, 8'h80}) begin
        n_fail++;
        $display("FAIL x_hold[%0d]: got %h expected %h", n, obs, {1'b1, 3'd7, 8'h80});
      end
    end
    drive(0, 8'h00, 1'b1);
    step();
    drive(0, 8'h00, 1'b0);
  endtask

  task automatic test_random();
    logic [11:0] obs;
    logic [11:0] exp;
    int          sel;
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < 2; m++) begin
        sel = $urandom_range(0, 3);
        ack_a[m] = ($urandom_range(0, 2) != 0);
        if (sel == 0)      req_a[m] = 8'h00;
        else if (sel == 1) req_a[m] = 8'h01 << $urandom_range(0, 7);
        else               req_a[m] = 8'($urandom);
        if (mv[m] && !ack_a[m] && $urandom_range(0, 4) == 0) req_a[m] = 8'bxxxx_xxxx;
      end
      step();
      for (int m = 0; m < 2; m++) begin
        exp = mv[m] ? {1'b1, 3'(mg[m]), 8'h01 << mg[m]} : 12'h000;
        obs = {valid_a[m], idx_a[m], grant_a[m]};
        n_checks++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL random[%0d] cycle %0d: got %h expected %h", m, c, obs, exp);
        end
        n_checks++;
        if (!$onehot0(grant_a[m]) || (valid_a[m] && grant_a[m][idx_a[m]] !== 1'b1)) begin
          n_fail++;
          $display("FAIL invariant[%0d] cycle %0d: grant %h idx %0d valid %b expected onehot with grant[idx]=1",
                   m, c, grant_a[m], idx_a[m], valid_a[m]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 8'h00, 1'b0);
    drive(1, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_fixed_hold();
    test_fixed_back_to_back();
    test_rr_rotation();
    test_rr_wrap();
    test_idle_ack();
    test_x_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
